led_uart_tx: RTL and testbench
==============================

# led_uart_tx

UART 8N1 transmitter that drives `ftdi_txd` from the 25 MHz board clock so the SOC can stream its LED pattern bytes, and later core debug output, to the host over the FTDI link. It sits downstream of the LED pattern sequencer. It accepts one byte per valid/ready handshake and serializes it LSB-first with start and stop bits at a parameterised baud rate.

## Interface
- `CLK_FREQ`, default 25000000: input clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `CLKS_PER_BIT` (localparam) = `CLK_FREQ/BAUD`, integer division, giving 217 at the defaults. Must be ≥ 2; elaboration fails otherwise.

Ports (clock and reset first):
- `clk_25mhz`, in, 1: system clock. This is the only clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `tx_data`, in, 8: byte to send. Sampled only on acceptance.
- `tx_valid`, in, 1: upstream has a byte.
- `tx_ready`, out, 1: transmitter idle and able to accept.
- `busy`, out, 1: a frame is in progress.
- `ftdi_txd`, out, 1: serial line, idle high.

## Operation
- States: IDLE, START, DATA, [PARITY], STOP.
- Reset (async, active-high):
  - State goes to IDLE, `ftdi_txd`=1, `busy`=0, and the bit and baud counters go to 0.
  - `tx_ready` is `state==IDLE && !rst`, so it reads 0 while `rst` is high and 1 afterwards.
- IDLE:
  - `tx_ready`=1 and `ftdi_txd`=1.
  - Acceptance is `tx_valid && tx_ready` at a rising edge. On that edge `tx_data` is latched into the shift register, the state goes to START, `ftdi_txd` goes to 0, and `busy` goes to 1.
- START: line held 0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA:
  - Eight bits are sent LSB first, each held `CLKS_PER_BIT` cycles.
  - A 3-bit index wraps 7→0 on the exit to the next state (STOP, or PARITY when enabled).
- STOP: line held 1 for `CLKS_PER_BIT` cycles, then IDLE, with `busy`=0 and `tx_ready`=1.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT)`.
  - Counts 0..`CLKS_PER_BIT`-1 and advances the bit at terminal count.
  - It never wraps mid-bit.
- `ftdi_txd` is driven from a register, so there is no combinational path from inputs to the line.
- Changes on `tx_data` or `tx_valid` during a frame are ignored. No byte is accepted while `busy`=1.
- A reset in mid-frame aborts the frame:
  - The line returns high immediately, asynchronously.
  - The latched byte is discarded and not resent.

## Timing
- Acceptance edge N: `ftdi_txd` is low from edge N. `tx_ready` and `busy` update at the same edge.
- Bit k (with start = 0, data = 1..8, stop = 9) occupies edges N+k·`CLKS_PER_BIT` up to N+(k+1)·`CLKS_PER_BIT`−1.
- Frame length is 10·`CLKS_PER_BIT` cycles, which is 2170 cycles at the defaults (11·`CLKS_PER_BIT` with parity).
- `tx_ready` rises at edge N+10·`CLKS_PER_BIT`.
- With `tx_valid` held high continuously, the next acceptance happens one cycle later. The frame period is therefore 10·`CLKS_PER_BIT`+1 cycles, including one idle-high cycle between frames.
- If `tx_valid` rises in the same cycle `tx_ready` rises, the byte is accepted at the next edge.

## Configuration
- Macro `LED_UART_TX_PARITY_EN`.
- Defined:
  - The PARITY state is inserted between DATA and STOP.
  - It sends an even parity bit, `^data`, for `CLKS_PER_BIT` cycles.
  - The frame is 11 bits (8E1).
- Undefined: the PARITY state and its logic are absent, and the frame is 8N1 at 10 bits.

## Test plan
- **Reset values:** Assert `rst` mid-simulation for 3 cycles with `tx_valid`=1.
  - During reset: `ftdi_txd`=1, `tx_ready`=0, `busy`=0.
  - After release: `tx_ready`=1.
- **Single byte 0xA5:** Hold `tx_valid` for one cycle.
  - Sampling mid-bit every 217 cycles gives 0, 1,0,1,0,0,1,0,1, then 1.
  - `tx_ready` is high again exactly 2170 cycles after acceptance.
- **Back-to-back 0x00 then 0xFF with `tx_valid` held:**
  - The second start bit falls 2171 cycles after the first.
  - The line is high for exactly 1 cycle plus the stop bit between frames.
- **Data change during frame:** Send 0x3C, then drive `tx_data`=0xFF and `tx_valid`=1 mid-frame.
  - The line still carries 0x3C.
  - 0xFF is accepted only after `tx_ready` rises.
- **Reset mid-frame:** Pulse `rst` at bit 4 of 0x55.
  - `ftdi_txd` goes to 1 asynchronously and stays high.
  - The byte is not retransmitted.
- **Parity (`LED_UART_TX_PARITY_EN` defined):**
  - Byte 0x07 gives parity bit 1, and byte 0x03 gives 0.
  - The frame lasts 2387 cycles.

Source files
------------

// File: rtl/led_uart_tx.sv
// UART 8N1 transmitter for the FTDI link: one byte per valid/ready handshake, LSB first.
// Define LED_UART_TX_PARITY_EN to insert an even parity bit between data and stop (8E1).
module led_uart_tx #(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_25mhz,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       ftdi_txd
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_rate
            $error("led_uart_tx: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

`ifdef LED_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] baud_cnt_r, baud_cnt_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [7:0]       data_r, data_s;
    logic             txd_r, txd_s;
    logic             busy_r, busy_s;
    logic             bit_done_s;

    // Next-state, next-line-level and counter logic for the frame sequencer
    always_comb begin
        state_s    = state_r;
        bit_idx_s  = bit_idx_r;
        data_s     = data_r;
        txd_s      = txd_r;
        busy_s     = busy_r;
        bit_done_s = (baud_cnt_r == BAUD_LAST);

        // Counter runs only inside a frame and restarts exactly at each bit boundary
        if (state_r == ST_IDLE || bit_done_s) begin
            baud_cnt_s = '0;
        end else begin
            baud_cnt_s = baud_cnt_r + CNT_W'(1);
        end

        case (state_r)
            ST_IDLE: begin
                bit_idx_s = 3'd0;
                if (tx_valid) begin
                    data_s  = tx_data;
                    state_s = ST_START;
                    txd_s   = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    txd_s  = 1'b1;
                    busy_s = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_s = ST_DATA;
                    txd_s   = data_r[0];
                end else begin
                    txd_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_s = 3'd0;
`ifdef LED_UART_TX_PARITY_EN
                        state_s   = ST_PARITY;
                        txd_s     = even_parity(data_r);
`else
                        state_s   = ST_STOP;
                        txd_s     = 1'b1;
`endif
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        txd_s     = data_r[bit_idx_s];
                    end
                end else begin
                    txd_s = data_r[bit_idx_r];
                end
            end
`ifdef LED_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_s = ST_STOP;
                    txd_s   = 1'b1;
                end else begin
                    txd_s = even_parity(data_r);
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_s) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    busy_s = 1'b1;
                end
                txd_s = 1'b1;
            end
            default: begin
                state_s    = ST_IDLE;
                baud_cnt_s = '0;
                bit_idx_s  = 3'd0;
                txd_s      = 1'b1;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the line high without waiting for a clock
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            data_r     <= 8'h00;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_idx_r  <= bit_idx_s;
            data_r     <= data_s;
            txd_r      <= txd_s;
            busy_r     <= busy_s;
        end
    end

    assign tx_ready = (state_r == ST_IDLE) && !rst;
    assign busy     = busy_r;
    assign ftdi_txd = txd_r;

endmodule

// File: tb/tb_led_uart_tx.sv
// Directed self-checking bench for led_uart_tx at the default 25 MHz / 115200 baud.
// Honors LED_UART_TX_PARITY_EN to expect 11-bit 8E1 frames.
module tb_led_uart_tx;

    localparam int CPB  = 217;
    localparam int HALF = 108;
`ifdef LED_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk_25mhz = 1'b0;
    logic       rst       = 1'b1;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       ftdi_txd;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    led_uart_tx dut (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .ftdi_txd  (ftdi_txd)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    always @(posedge clk_25mhz) cyc <= cyc + 1;

    // Line bits indexed by position: 0 start, 1..8 data, then [parity], stop
    function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef LED_UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    task automatic capture_frame(output logic [10:0] bits);
        bits = 11'h000;
        repeat (HALF) @(negedge clk_25mhz);
        bits[0] = ftdi_txd;
        for (int k = 1; k < NB; k++) begin
            repeat (CPB) @(negedge clk_25mhz);
            bits[k] = ftdi_txd;
        end
    endtask

    task automatic send_one(input logic [7:0] d, output int n);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_25mhz);
        tx_valid = 1'b0;
        n = cyc;
    endtask

    task automatic wait_ready(output int n, output logic ok);
        int i;
        i = 0;
        while (!tx_ready && i < 3000) begin
            @(negedge clk_25mhz);
            i++;
        end
        ok = tx_ready;
        n  = cyc;
    endtask

    task automatic test_reset();
        int n, m;
        logic ok;
        @(negedge clk_25mhz);
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_25mhz);
            checks++;
            if ({ftdi_txd, tx_ready, busy} !== 3'b100) begin
                failures++;
                $display("FAIL reset_hold: txd/ready/busy=%b expected 100", {ftdi_txd, tx_ready, busy});
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b expected 1", tx_ready);
        end
        @(negedge clk_25mhz);
        n = cyc;
        tx_valid = 1'b0;
        checks++;
        if ({ftdi_txd, busy, tx_ready} !== 3'b010) begin
            failures++;
            $display("FAIL reset_first_accept: txd/busy/ready=%b expected 010", {ftdi_txd, busy, tx_ready});
        end
        wait_ready(m, ok);
        checks++;
        if (!ok || (m - n) != FRAME) begin
            failures++;
            $display("FAIL reset_frame_len: got %0d expected %0d", m - n, FRAME);
        end
    endtask

    task automatic test_single_byte();
        int n, m;
        logic ok;
        logic [10:0] bits;
        @(negedge clk_25mhz);
        send_one(8'hA5, n);
        checks++;
        if ({ftdi_txd, busy, tx_ready} !== 3'b010) begin
            failures++;
            $display("FAIL single_accept: txd/busy/ready=%b expected 010", {ftdi_txd, busy, tx_ready});
        end
        capture_frame(bits);
        checks++;
        if (bits !== frame_of(8'hA5)) begin
            failures++;
            $display("FAIL single_bits: got %b expected %b", bits, frame_of(8'hA5));
        end
        checks++;
        if (tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_ready_in_stop: got %b expected 0", tx_ready);
        end
        wait_ready(m, ok);
        checks++;
        if (!ok || (m - n) != FRAME) begin
            failures++;
            $display("FAIL single_ready_time: got %0d expected %0d", m - n, FRAME);
        end
        checks++;
        if ({busy, ftdi_txd} !== 2'b01) begin
            failures++;
            $display("FAIL single_idle: busy/txd=%b expected 01", {busy, ftdi_txd});
        end
    endtask

    task automatic test_back_to_back();
        int f1, f2, run, high_run, m;
        logic prev, ok;
        logic [10:0] bits;
        f1 = -1; f2 = -1; run = 0; high_run = 0; prev = 1'b1;
        @(negedge clk_25mhz);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        for (int i = 0; i < 6000 && f2 < 0; i++) begin
            @(negedge clk_25mhz);
            if (ftdi_txd) begin
                run++;
            end else begin
                if (prev) begin
                    if (f1 < 0) begin
                        f1 = cyc;
                        tx_data = 8'hFF;
                    end else begin
                        f2 = cyc;
                        high_run = run;
                    end
                end
                run = 0;
            end
            prev = ftdi_txd;
        end
        tx_valid = 1'b0;
        checks++;
        if (f1 < 0 || f2 < 0 || (f2 - f1) != FRAME + 1) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d expected %0d", f2 - f1, FRAME + 1);
        end
        checks++;
        if (high_run != CPB + 1) begin
            failures++;
            $display("FAIL b2b_gap: got %0d expected %0d", high_run, CPB + 1);
        end
        capture_frame(bits);
        checks++;
        if (bits !== frame_of(8'hFF)) begin
            failures++;
            $display("FAIL b2b_second_bits: got %b expected %b", bits, frame_of(8'hFF));
        end
        wait_ready(m, ok);
        checks++;
        if (!ok || (m - f2) != FRAME) begin
            failures++;
            $display("FAIL b2b_ready: got %0d expected %0d", m - f2, FRAME);
        end
    endtask

    task automatic test_data_change();
        int n, f, m;
        logic ok;
        logic [10:0] bits;
        @(negedge clk_25mhz);
        send_one(8'h3C, n);
        @(negedge clk_25mhz);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        capture_frame(bits);
        checks++;
        if (bits !== frame_of(8'h3C)) begin
            failures++;
            $display("FAIL change_bits: got %b expected %b", bits, frame_of(8'h3C));
        end
        checks++;
        if ({busy, tx_ready} !== 2'b10) begin
            failures++;
            $display("FAIL change_busy: busy/ready=%b expected 10", {busy, tx_ready});
        end
        f = -1;
        for (int i = 0; i < 500 && f < 0; i++) begin
            @(negedge clk_25mhz);
            if (!ftdi_txd) f = cyc;
        end
        tx_valid = 1'b0;
        checks++;
        if (f < 0 || (f - n) != FRAME + 1) begin
            failures++;
            $display("FAIL change_accept_time: got %0d expected %0d", f - n, FRAME + 1);
        end
        capture_frame(bits);
        checks++;
        if (bits !== frame_of(8'hFF)) begin
            failures++;
            $display("FAIL change_second_bits: got %b expected %b", bits, frame_of(8'hFF));
        end
        wait_ready(m, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL change_ready: got %b expected 1", ok);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n, lows, busies;
        @(negedge clk_25mhz);
        send_one(8'h55, n);
        repeat (900) @(negedge clk_25mhz);
        checks++;
        if (ftdi_txd !== 1'b0) begin
            failures++;
            $display("FAIL midreset_bit4: got %b expected 0", ftdi_txd);
        end
        #5;
        rst = 1'b1;
        #1;
        checks++;
        if ({ftdi_txd, busy, tx_ready} !== 3'b100) begin
            failures++;
            $display("FAIL midreset_async: txd/busy/ready=%b expected 100", {ftdi_txd, busy, tx_ready});
        end
        @(negedge clk_25mhz);
        rst = 1'b0;
        lows = 0; busies = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk_25mhz);
            if (!ftdi_txd) lows++;
            if (busy) busies++;
        end
        checks++;
        if (lows != 0 || busies != 0) begin
            failures++;
            $display("FAIL midreset_no_resend: low=%0d busy=%0d expected 0 0", lows, busies);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ready: got %b expected 1", tx_ready);
        end
    endtask

`ifdef LED_UART_TX_PARITY_EN
    task automatic test_parity();
        int n, m;
        logic ok;
        logic [10:0] bits;
        @(negedge clk_25mhz);
        send_one(8'h07, n);
        capture_frame(bits);
        checks++;
        if (bits[9] !== 1'b1 || bits !== 11'b1_1_00000111_0) begin
            failures++;
            $display("FAIL parity_07: got %b expected %b", bits, 11'b1_1_00000111_0);
        end
        wait_ready(m, ok);
        checks++;
        if (!ok || (m - n) != 2387) begin
            failures++;
            $display("FAIL parity_frame_len: got %0d expected 2387", m - n);
        end
        @(negedge clk_25mhz);
        send_one(8'h03, n);
        capture_frame(bits);
        checks++;
        if (bits[9] !== 1'b0 || bits !== 11'b1_0_00000011_0) begin
            failures++;
            $display("FAIL parity_03: got %b expected %b", bits, 11'b1_0_00000011_0);
        end
        wait_ready(m, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL parity_ready: got %b expected 1", ok);
        end
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk_25mhz);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_data_change();
        test_reset_mid_frame();
`ifdef LED_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
